// File: rtl/usb_cdc_in_sched_pkg.sv
// Shared types and defaults for the USB CDC IN burst scheduler.
package usb_cdc_sched_pkg;

   localparam int MAX_SRC          = 4;
   localparam int SRC_IDX_W        = $clog2(MAX_SRC);
   localparam int BURST_LEN_DEF    = 8;
   localparam int IDLE_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      END  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/usb_cdc_in_sched_if.sv
// Byte-stream link from the scheduler to the usb_cdc IN data port.
interface usb_cdc_in_sched_if;
   logic [7:0] in_data_o;
   logic       in_valid_o;
   logic       in_ready_i;

   modport master (output in_data_o, output in_valid_o, input in_ready_i);
   modport slave  (input in_data_o, input in_valid_o, output in_ready_i);
endinterface

// File: rtl/usb_cdc_rr_pick.sv
// Combinational rotating-priority picker: first requester at or above ptr_i
// (with wrap-around) wins. Optional macro USB_CDC_SCHED_PRIO_EN gives source 0
// strict priority and rotates the pointer over sources 1..NUM_SRC-1 only.
module usb_cdc_rr_pick
   import usb_cdc_sched_pkg::*;
#(
   parameter int NUM_SRC = 2
) (
   input  logic [NUM_SRC-1:0]   req_i,
   input  logic [SRC_IDX_W-1:0] ptr_i,
   output logic [NUM_SRC-1:0]   gnt_o,
   output logic [SRC_IDX_W-1:0] idx_o,
   output logic                 any_o
);

   logic                 found;
   logic [SRC_IDX_W-1:0] cand_idx;
   int                   cand;
`ifdef USB_CDC_SCHED_PRIO_EN
   int                   base;
`endif

   assign any_o = |req_i;

   // search upward from the pointer, first requesting source wins
   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
`ifdef USB_CDC_SCHED_PRIO_EN
      if (req_i[0]) begin
         gnt_o[0] = 1'b1;
         found    = 1'b1;
      end
      // a pointer left at 0 means "start of the rotating group"
      base = (ptr_i == '0) ? 1 : int'(ptr_i);
      for (int i = 0; i < NUM_SRC - 1; i++) begin
         cand = base + i;
         if (cand >= NUM_SRC) cand = cand - (NUM_SRC - 1);
         cand_idx = SRC_IDX_W'(cand);
         if (!found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
`else
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = int'(ptr_i) + i;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         cand_idx = SRC_IDX_W'(cand);
         if (!found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
`endif
   end

endmodule

// File: rtl/usb_cdc_in_sched.sv
// Burst-granular round-robin scheduler feeding the usb_cdc IN byte stream.
// Optional macro USB_CDC_SCHED_PRIO_EN: source 0 has strict priority.
//
//   state | meaning
//   IDLE  | waiting for enable_i and a valid source; arbitrate
//   XFER  | granted source streams up to BURST_LEN bytes
//   END   | one-cycle burst_done_o, advance rr_ptr, clear counters
module usb_cdc_in_sched
   import usb_cdc_sched_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int BURST_LEN    = BURST_LEN_DEF,
   parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 enable_i,
   input  logic [8*NUM_SRC-1:0] src_data_i,
   input  logic [NUM_SRC-1:0]   src_valid_i,
   output logic [NUM_SRC-1:0]   src_ready_o,
   usb_cdc_in_sched_if.master   usb_if,
   output logic [NUM_SRC-1:0]   grant_o,
   output logic                 busy_o,
   output logic                 burst_done_o
);

   localparam int BCW = $clog2(BURST_LEN + 1);
   localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [BCW-1:0] BYTE_MAX = BCW'(BURST_LEN);
   localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_TIMEOUT);

   sched_state_e         state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [SRC_IDX_W-1:0] gidx_q, gidx_d;
   logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
   logic [ICW-1:0]       idle_cnt_q, idle_cnt_d;

   logic [NUM_SRC-1:0]   pick_gnt;
   logic [SRC_IDX_W-1:0] pick_idx;
   logic                 pick_any;
   logic                 gnt_valid;
   logic [SRC_IDX_W-1:0] rr_next;

   usb_cdc_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .req_i (src_valid_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign gnt_valid = |(src_valid_i & grant_q);

   // pointer value after the current burst: one past the owner, with wrap
   always_comb begin
      if (gidx_q == SRC_IDX_W'(NUM_SRC - 1)) rr_next = '0;
      else                                   rr_next = gidx_q + 1'b1;
`ifdef USB_CDC_SCHED_PRIO_EN
      if (gidx_q == '0) rr_next = rr_ptr_q;
`endif
   end

   // state register and burst bookkeeping
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // next state; byte-count exit is checked before the idle timeout
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
      idle_cnt_d = idle_cnt_q;
      case (state_q)
         IDLE: begin
            if (enable_i && pick_any) begin
               state_d    = XFER;
               grant_d    = pick_gnt;
               gidx_d     = pick_idx;
               byte_cnt_d = '0;
               idle_cnt_d = '0;
            end
         end
         XFER: begin
            if (gnt_valid && usb_if.in_ready_i) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               idle_cnt_d = '0;
               if (byte_cnt_d == BYTE_MAX) begin
                  state_d = END;
                  grant_d = '0;
               end
            end else if (gnt_valid) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
               if (idle_cnt_d == IDLE_MAX) begin
                  state_d = END;
                  grant_d = '0;
               end
            end
         end
         END: begin
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = rr_next;
            byte_cnt_d = '0;
            idle_cnt_d = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // datapath: everything keyed off the registered grant (zero outside XFER)
   always_comb begin
      usb_if.in_data_o = 8'h00;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (grant_q[k]) usb_if.in_data_o = src_data_i[8*k +: 8];
      end
      usb_if.in_valid_o = gnt_valid;
      src_ready_o       = grant_q & {NUM_SRC{usb_if.in_ready_i}};
      grant_o           = grant_q;
      busy_o            = (state_q != IDLE);
      burst_done_o      = (state_q == END);
   end

endmodule

// File: tb/tb_usb_cdc_in_sched.sv
// Bench for usb_cdc_in_sched: per-source byte models, scoreboard of expected
// (grant, byte) pairs and burst lengths, table of multi-source scenarios plus
// hand sequences for latency, stalls, enable drop and mid-burst reset.
module tb_usb_cdc_in_sched;

   localparam int NS = 2;
   localparam int BL = 8;
   localparam int IT = 16;

   logic            PCLK = 1'b0;
   logic            PRESETn = 1'b0;
   logic            enable_i = 1'b0;
   logic [8*NS-1:0] src_data_i = '0;
   logic [NS-1:0]   src_valid_i = '0;
   logic [NS-1:0]   src_ready_o;
   logic [NS-1:0]   grant_o;
   logic            busy_o;
   logic            burst_done_o;

   usb_cdc_in_sched_if bus ();

   usb_cdc_in_sched #(.NUM_SRC(NS), .BURST_LEN(BL), .IDLE_TIMEOUT(IT)) dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .enable_i     (enable_i),
      .src_data_i   (src_data_i),
      .src_valid_i  (src_valid_i),
      .src_ready_o  (src_ready_o),
      .usb_if       (bus),
      .grant_o      (grant_o),
      .busy_o       (busy_o),
      .burst_done_o (burst_done_o)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [NS-1:0] gnt;
      logic [7:0]    data;
   } exp_t;

   typedef struct {
      int            n0;
      int            n1;
      logic [7:0]    b0;
      logic [7:0]    b1;
      bit            tog;
      int            exp_bursts;
      logic [NS-1:0] exp_first;
   } vec_t;

   exp_t          exp_q[$];
   int            bl_q[$];
   int            done_cyc[$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            left[NS];
   int            sent[NS];
   int            stall_at[NS];
   int            stall_rem[NS];
   logic [7:0]    nxt[NS];
   int            model_ptr = 0;
   bit            toggle_rdy = 1'b0;
   int            cyc = 0;
   int            n_done = 0;
   int            burst_bytes = 0;
   bit            want_first = 1'b0;
   logic [NS-1:0] first_gnt;
   int            first_cyc;
   logic          prev_stall = 1'b0;
   logic [7:0]    prev_data = 8'h00;
   vec_t          vecs[4];

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endfunction

   // reference arbiter: RR over sources with bytes left, bursts of min(BL, left)
   function automatic void plan();
      int         l[NS];
      logic [7:0] n[NS];
      int         k, b, p, j;
      bit         any;
      exp_t       e;
      for (int i = 0; i < NS; i++) begin
         l[i] = left[i];
         n[i] = nxt[i];
      end
      any = 1'b1;
      while (any) begin
         k = -1;
`ifdef USB_CDC_SCHED_PRIO_EN
         if (l[0] > 0) k = 0;
         p = (model_ptr == 0) ? 1 : model_ptr;
         for (int i = 0; i < NS - 1; i++) begin
            j = p + i;
            if (j >= NS) j = j - (NS - 1);
            if (k < 0 && l[j] > 0) k = j;
         end
`else
         p = model_ptr;
         for (int i = 0; i < NS; i++) begin
            j = (p + i) % NS;
            if (k < 0 && l[j] > 0) k = j;
         end
`endif
         if (k < 0) begin
            any = 1'b0;
         end else begin
            b = (l[k] < BL) ? l[k] : BL;
            for (int i = 0; i < b; i++) begin
               e.gnt    = '0;
               e.gnt[k] = 1'b1;
               e.data   = n[k];
               exp_q.push_back(e);
               n[k]++;
            end
            l[k] -= b;
            bl_q.push_back(b);
`ifdef USB_CDC_SCHED_PRIO_EN
            if (k != 0) model_ptr = (k + 1) % NS;
`else
            model_ptr = (k + 1) % NS;
`endif
         end
      end
   endfunction

   task automatic push_bytes(int k, logic [7:0] base, int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.gnt    = '0;
         e.gnt[k] = 1'b1;
         e.data   = base + 8'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NS; k++) begin
         src_valid_i[k] = (left[k] > 0);
         if (left[k] > 0 && sent[k] == stall_at[k] && stall_rem[k] > 0) begin
            src_valid_i[k] = 1'b0;
            stall_rem[k]--;
         end
         src_data_i[8*k +: 8] = nxt[k];
      end
      bus.in_ready_i = toggle_rdy ? ~bus.in_ready_i : 1'b1;
   endtask

   task automatic setup_src(int k, int n, logic [7:0] base);
      left[k]      = n;
      nxt[k]       = base;
      sent[k]      = 0;
      stall_at[k]  = -1;
      stall_rem[k] = 0;
   endtask

   // one clock: observe at the falling edge, advance sources after the rising edge
   task automatic cycle();
      exp_t          e;
      logic [NS-1:0] hs;
      @(negedge PCLK);
      hs = src_valid_i & src_ready_o;
      if (bus.in_valid_o && bus.in_ready_i) begin
         if (want_first) begin
            first_gnt  = grant_o;
            first_cyc  = cyc;
            want_first = 1'b0;
         end
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h grant %0b, required no byte", bus.in_data_o, grant_o);
         end else begin
            e = exp_q.pop_front();
            check("byte_data", 32'(bus.in_data_o), 32'(e.data));
            check("byte_grant", 32'(grant_o), 32'(e.gnt));
         end
         burst_bytes++;
      end
      if (prev_stall && bus.in_valid_o) check("stall_hold", 32'(bus.in_data_o), 32'(prev_data));
      prev_stall = bus.in_valid_o && !bus.in_ready_i;
      prev_data  = bus.in_data_o;
      if (burst_done_o) begin
         check("done_quiet", 32'({grant_o, bus.in_valid_o, src_ready_o}), 32'd0);
         if (bl_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got pulse after %0d bytes, required none", burst_bytes);
         end else begin
            check("burst_len", 32'(burst_bytes), 32'(bl_q.pop_front()));
         end
         burst_bytes = 0;
         n_done++;
         done_cyc.push_back(cyc);
      end
      @(posedge PCLK);
      #1;
      for (int k = 0; k < NS; k++) begin
         if (hs[k]) begin
            left[k]--;
            sent[k]++;
            nxt[k]++;
         end
      end
      cyc++;
      drive();
   endtask

   task automatic run_until(int target, int budget);
      int c = 0;
      while ((n_done < target || exp_q.size() != 0) && c < budget) begin
         cycle();
         c++;
      end
      if (c >= budget) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: got %0d bursts, required %0d", n_done, target);
      end
   endtask

   task automatic reset_dut();
      PRESETn    = 1'b0;
      toggle_rdy = 1'b0;
      for (int k = 0; k < NS; k++) setup_src(k, 0, 8'h00);
      drive();
      repeat (2) @(posedge PCLK);
      #1;
      PRESETn     = 1'b1;
      model_ptr   = 0;
      burst_bytes = 0;
      prev_stall  = 1'b0;
      exp_q.delete();
      bl_q.delete();
   endtask

   initial begin
      int s, d0;
      bus.in_ready_i = 1'b1;
      for (int k = 0; k < NS; k++) setup_src(k, 0, 8'h00);

      vecs[0] = '{16, 16, 8'hA0, 8'hB0, 1'b0, 4, 2'b01};
      vecs[1] = '{16, 16, 8'h10, 8'h20, 1'b1, 4, 2'b01};
      vecs[2] = '{0,  10, 8'h00, 8'h30, 1'b0, 2, 2'b10};
      vecs[3] = '{5,  12, 8'h50, 8'h70, 1'b0, 3, 2'b01};

      // reset values
      #2;
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(burst_done_o), 32'd0);
      check("rst_in_valid", 32'(bus.in_valid_o), 32'd0);
      check("rst_in_data", 32'(bus.in_data_o), 32'd0);
      check("rst_src_ready", 32'(src_ready_o), 32'd0);
      reset_dut();
      enable_i = 1'b1;

      // single source, 20 bytes: 8,8,4 with fixed spacing
      setup_src(0, 20, 8'h00);
      plan();
      done_cyc.delete();
      s = cyc;
      want_first = 1'b1;
      drive();
      run_until(n_done + 3, 200);
      check("grant_latency", 32'(first_cyc - s), 32'd1);
      if (done_cyc.size() == 3) begin
         check("first_done_cyc", 32'(done_cyc[0] - s), 32'd9);
         check("burst_gap", 32'(done_cyc[1] - done_cyc[0]), 32'(BL + 2));
         check("timeout_tail", 32'(done_cyc[2] - done_cyc[1]), 32'(4 + IT + 2));
      end else begin
         check("done_pulses", 32'(done_cyc.size()), 32'd3);
      end

      // table of multi-source scenarios from a known pointer
      reset_dut();
      for (int v = 0; v < 4; v++) begin
         setup_src(0, vecs[v].n0, vecs[v].b0);
         setup_src(1, vecs[v].n1, vecs[v].b1);
         toggle_rdy = vecs[v].tog;
         d0         = n_done;
         want_first = 1'b1;
         plan();
         drive();
         run_until(d0 + vecs[v].exp_bursts, 600);
         check("vec_bursts", 32'(n_done - d0), 32'(vecs[v].exp_bursts));
         check("vec_first_grant", 32'(first_gnt), 32'(vecs[v].exp_first));
      end
      toggle_rdy = 1'b0;

      // stall of 10 cycles after 3 bytes: burst still reaches 8
      reset_dut();
      setup_src(0, 8, 8'h80);
      stall_at[0]  = 3;
      stall_rem[0] = 10;
      push_bytes(0, 8'h80, 8);
      bl_q.push_back(8);
      d0 = n_done;
      drive();
      run_until(d0 + 1, 200);
      check("stall10_bursts", 32'(n_done - d0), 32'd1);

      // stall of IT cycles after 3 bytes: early END, pointer moves to source 1
      reset_dut();
      setup_src(0, 8, 8'h90);
      setup_src(1, 8, 8'hC0);
      stall_at[0]  = 3;
      stall_rem[0] = IT;
      push_bytes(0, 8'h90, 3);
      push_bytes(1, 8'hC0, 8);
      push_bytes(0, 8'h93, 5);
      bl_q.push_back(3);
      bl_q.push_back(8);
      bl_q.push_back(5);
      d0 = n_done;
      drive();
      run_until(d0 + 3, 300);
      check("stall16_bursts", 32'(n_done - d0), 32'd3);

      // enable dropped after byte 2: burst completes, then no new grant
      reset_dut();
      setup_src(0, 20, 8'h40);
      push_bytes(0, 8'h40, 8);
      bl_q.push_back(8);
      d0 = n_done;
      drive();
      for (int c = 0; c < 20 && sent[0] < 2; c++) cycle();
      enable_i = 1'b0;
      run_until(d0 + 1, 100);
      repeat (20) cycle();
      check("disabled_grant", 32'(grant_o), 32'd0);
      check("disabled_busy", 32'(busy_o), 32'd0);
      check("disabled_left", 32'(left[0]), 32'd12);

      // mid-burst reset: outputs drop at once, pointer returns to 0
      setup_src(1, 8, 8'h60);
      enable_i = 1'b1;
      push_bytes(1, 8'h60, 3);
      drive();
      for (int c = 0; c < 20 && sent[1] < 3; c++) cycle();
      check("pre_reset_busy", 32'(busy_o), 32'd1);
      PRESETn = 1'b0;
      #1;
      check("mid_rst_grant", 32'(grant_o), 32'd0);
      check("mid_rst_valid", 32'(bus.in_valid_o), 32'd0);
      check("mid_rst_ready", 32'(src_ready_o), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_done", 32'(burst_done_o), 32'd0);
      check("mid_rst_data", 32'(bus.in_data_o), 32'd0);
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      PRESETn     = 1'b1;
      burst_bytes = 0;
      prev_stall  = 1'b0;
      model_ptr   = 0;
      check("post_rst_queue", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      d0         = n_done;
      want_first = 1'b1;
      plan();
      run_until(d0 + 3, 300);
      check("post_rst_first", 32'(first_gnt), 32'b01);
      check("post_rst_bursts", 32'(n_done - d0), 32'd3);

      repeat (4) cycle();
      check("final_bl_q", 32'(bl_q.size()), 32'd0);
      check("final_exp_q", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
